// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and a constant-foldable ceil(log2) helper for counter sizing.
package seq_mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_shift_add_if.sv
// Start/ready/done handshake and operand/product bus of the sequential multiplier.
interface seq_mult_shift_add_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     m;
    logic [WIDTH-1:0]     q;
    logic                 ready;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, m, q,
        input  ready, done, product
    );

    modport slave (
        input  start, m, q,
        output ready, done, product
    );
endinterface

// File: rtl/pp_gen_nbit.sv
// Generalised partial-product cell: the multiplicand gated by a single multiplier bit.
module pp_gen_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_mcand,
    input  logic             i_qbit,
    output logic [WIDTH-1:0] o_pp
);
    assign o_pp = i_mcand & {WIDTH{i_qbit}};
endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-add unsigned multiplier, one partial product per clock.
// Define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult_shift_add
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    seq_mult_shift_add_if.slave bus
);
    localparam int             CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_count;
    logic                 r_ready;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_pp;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_mplier_next;
    logic                 w_exit;
    logic [2*WIDTH-1:0]   w_result;

    pp_gen_nbit #(.WIDTH(WIDTH)) u_pp_gen (
        .i_mcand (r_mcand),
        .i_qbit  (r_mplier[0]),
        .o_pp    (w_pp)
    );

    // Carry out of the upper half is kept and becomes the new MSB after the shift.
    assign w_sum         = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_pp};
    assign w_acc_next    = {w_sum, r_acc[WIDTH-1:1]};
    assign w_mplier_next = r_mplier >> 1;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Stopping early leaves acc short of its final shifts; realign by the iterations skipped.
    assign w_exit   = (r_count == LAST) || (w_mplier_next == '0);
    assign w_result = w_acc_next >> (LAST - r_count);
`else
    assign w_exit   = (r_count == LAST);
    assign w_result = w_acc_next;
`endif

    // NOTE: state is updated only with non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand  <= bus.m;
                        r_mplier <= bus.q;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_ready  <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= w_mplier_next;
                    r_count  <= r_count + CW'(1);
                    if (w_exit) begin
                        r_product <= w_result;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Self-checking bench for seq_mult_shift_add at WIDTH=4 and WIDTH=8 against an arithmetic model;
// run-length expectations follow SEQ_MULT_EARLY_EXIT_EN when it is defined.
module tb_seq_mult_shift_add;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seq_mult_shift_add_if #(.WIDTH(4)) bus4();
    seq_mult_shift_add_if #(.WIDTH(8)) bus8();

    seq_mult_shift_add #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    seq_mult_shift_add #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;

    // Expected number of RUN cycles for multiplier value qv.
    function automatic int runlen(input int w, input int qv);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int n;
        n = 1;
        for (int i = 0; i < w; i++)
            if (qv[i]) n = i + 1;
        return n;
`else
        return w + 0 * qv;
`endif
    endfunction

    task automatic run4(input logic [3:0] a, input logic [3:0] b, output logic [7:0] p,
                        output int lat, output logic rdy_run, output logic rdy_after,
                        output logic done_after, output logic [7:0] p_hold);
        @(negedge clk);
        bus4.m = a; bus4.q = b; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0; bus4.m = 4'($urandom); bus4.q = 4'($urandom);
        rdy_run = bus4.ready;
        lat = 0;
        while (bus4.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        p = bus4.product;
        @(negedge clk);
        rdy_after = bus4.ready; done_after = bus4.done; p_hold = bus4.product;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, output logic [15:0] p,
                        output int lat);
        @(negedge clk);
        bus8.m = a; bus8.q = b; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0; bus8.m = 8'($urandom); bus8.q = 8'($urandom);
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        p = bus8.product;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.start = 1'b1; bus4.m = 4'd9;  bus4.q = 4'd5;
        bus8.start = 1'b1; bus8.m = 8'd99; bus8.q = 8'd7;
        repeat (2) @(negedge clk);
        total++; if (bus4.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus4.ready); end
        total++; if (bus4.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus4.done); end
        total++; if (bus4.product !== 8'd0) begin bad++; $display("FAIL reset_product: got %0d want 0", bus4.product); end
        total++; if (bus8.product !== 16'd0) begin bad++; $display("FAIL reset_product8: got %0d want 0", bus8.product); end
        rst = 1'b0; bus4.start = 1'b0; bus8.start = 1'b0;
        @(negedge clk);
        total++; if (bus4.ready !== 1'b1) begin bad++; $display("FAIL reset_no_accept: ready got %b want 1", bus4.ready); end
    endtask

    task automatic test_max();
        logic [7:0] p, ph;
        int lat;
        logic rr, ra, da;
        run4(4'd15, 4'd15, p, lat, rr, ra, da, ph);
        total++; if (p !== 8'd225) begin bad++; $display("FAIL max_product: got %0d want 225", p); end
        total++; if (lat != runlen(4, 15)) begin bad++; $display("FAIL max_latency: got %0d want %0d", lat, runlen(4, 15)); end
        total++; if (rr !== 1'b0) begin bad++; $display("FAIL max_ready_in_run: got %b want 0", rr); end
        total++; if (ra !== 1'b1) begin bad++; $display("FAIL max_ready_after: got %b want 1", ra); end
        total++; if (da !== 1'b0) begin bad++; $display("FAIL max_done_pulse: got %b want 0", da); end
        total++; if (ph !== 8'd225) begin bad++; $display("FAIL max_product_hold: got %0d want 225", ph); end
    endtask

    task automatic test_corners();
        int ca[5] = '{0, 15, 0, 5, 5};
        int cb[5] = '{0, 0, 15, 1, 15};
        logic [7:0] p, ph;
        int lat;
        logic rr, ra, da;
        for (int i = 0; i < 5; i++) begin
            run4(4'(ca[i]), 4'(cb[i]), p, lat, rr, ra, da, ph);
            total++;
            if (p !== 8'(ca[i] * cb[i]) || lat != runlen(4, cb[i])) begin
                bad++;
                $display("FAIL corner_%0dx%0d: got %0d lat %0d want %0d lat %0d",
                         ca[i], cb[i], p, lat, ca[i] * cb[i], runlen(4, cb[i]));
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] p, ph;
        int lat;
        logic rr, ra, da;
        int errs;
        errs = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run4(4'(a), 4'(b), p, lat, rr, ra, da, ph);
                total++;
                if (p !== 8'(a * b) || lat != runlen(4, b)) begin
                    bad++; errs++;
                    if (errs <= 8)
                        $display("FAIL exh_%0dx%0d: got %0d lat %0d want %0d lat %0d",
                                 a, b, p, lat, a * b, runlen(4, b));
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        logic [7:0] p;
        dones = 0; p = '0;
        @(negedge clk);
        bus4.m = 4'd10; bus4.q = 4'd11; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.m = 4'd3; bus4.q = 4'd2;
        @(negedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus4.done === 1'b1) begin
                dones++;
                p = bus4.product;
            end
        end
        total++; if (p !== 8'd110) begin bad++; $display("FAIL ignore_product: got %0d want 110", p); end
        total++; if (dones != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    endtask

    task automatic test_abort();
        int dones;
        logic [7:0] p, ph;
        int lat;
        logic rr, ra, da;
        dones = 0;
        @(negedge clk);
        bus4.m = 4'd6; bus4.q = 4'd9; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus4.ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", bus4.ready); end
        total++; if (bus4.product !== 8'd0) begin bad++; $display("FAIL abort_product: got %0d want 0", bus4.product); end
        if (bus4.done === 1'b1) dones++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus4.done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        run4(4'd3, 4'd7, p, lat, rr, ra, da, ph);
        total++; if (p !== 8'd21) begin bad++; $display("FAIL abort_restart: got %0d want 21", p); end
    endtask

    task automatic test_w8();
        int ta[5] = '{255, 200, 9, 0, 128};
        int tq[5] = '{255, 1, 0, 255, 128};
        logic [15:0] p;
        int lat;
        int a, b;
        for (int i = 0; i < 5; i++) begin
            run8(8'(ta[i]), 8'(tq[i]), p, lat);
            total++;
            if (p !== 16'(ta[i] * tq[i]) || lat != runlen(8, tq[i])) begin
                bad++;
                $display("FAIL w8_%0dx%0d: got %0d lat %0d want %0d lat %0d",
                         ta[i], tq[i], p, lat, ta[i] * tq[i], runlen(8, tq[i]));
            end
        end
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run8(8'(a), 8'(b), p, lat);
            total++;
            if (p !== 16'(a * b) || lat != runlen(8, b)) begin
                bad++;
                $display("FAIL w8_rand_%0dx%0d: got %0d lat %0d want %0d lat %0d",
                         a, b, p, lat, a * b, runlen(8, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_corners();
        test_exhaustive();
        test_ignore_start();
        test_abort();
        test_w8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
